// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS control logic: opcode encodings, the 3-bit
// ALU operation codes handed to the ALU decoder, and the state encoding of the
// multicycle controller.
// ----------------------------------------------------------------------------
package mips_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation requested from the ALU decoder
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;
    localparam logic [2:0] ALUOP_AND   = 3'b100;

    // Multicycle controller states; codes 12..15 are unused
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } ctrl_state_t;

endpackage

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
// Moore FSM sequencing a shared single-ALU / single-memory multicycle MIPS
// datapath, one instruction at a time.
//
// Handshake: mem_ready is a completion strobe. In FETCH, MEMRD and MEMWR the
// controller holds its outputs (address select, write strobe) unchanged and
// stays in the state until it sees mem_ready=1 at a rising edge; that edge
// completes the access and advances the FSM. In every other state mem_ready
// is ignored. With USE_MEM_READY=0 every access completes in one cycle.
//
// Ports:
//   clk, reset         clock (rising edge), synchronous active-high reset
//   op                 opcode from the instruction register
//   zero               ALU zero flag (branch resolution)
//   mem_ready          memory completes the current access this cycle
//   irwrite, pcwrite   instruction register load, unconditional PC write
//   pcen               final PC enable including branch resolution
//   branch, bne        beq / bne compare active
//   iord, memwrite     memory address select, memory write strobe
//   regwrite, regdst   register-file write, destination select (1 = rd)
//   memtoreg           write-back data from memory data register
//   alusrca, alusrcb   ALU operand selects
//   pcsrc, aluop       next-PC select, ALU operation
//   immext             1 = zero-extend immediate
//   illegal_op         unsupported opcode seen in DECODE
//   state_o            current state, for debug
// ----------------------------------------------------------------------------
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       pcen,
    output logic       branch,
    output logic       bne,
    output logic       iord,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] aluop,
    output logic       immext,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    ctrl_state_t state;
    ctrl_state_t state_next;
    logic [5:0]  op_q;
    logic        mem_done;

    // Raw (ungated) versions of the signals that reset must suppress.
    logic        irwrite_raw;
    logic        pcwrite_raw;
    logic        branch_raw;
    logic        bne_raw;
    logic        memwrite_raw;
    logic        regwrite_raw;
    logic        illegal_raw;

    logic        imm_zext;

    assign mem_done = USE_MEM_READY ? mem_ready : 1'b1;

    // ori/andi zero-extend; addi sign-extends. Held through write-back so the
    // immediate path stays stable until the register write completes.
    assign imm_zext = (op_q == OP_ORI) || (op_q == OP_ANDI);

    // ------------------------------------------------------------------------
    // State and opcode registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            op_q  <= 6'd0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                op_q <= op;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        state_next   = S_FETCH;
        irwrite_raw  = 1'b0;
        pcwrite_raw  = 1'b0;
        branch_raw   = 1'b0;
        bne_raw      = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        illegal_raw  = 1'b0;
        iord         = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        aluop        = ALUOP_ADD;
        immext       = 1'b0;

        case (state)
            S_FETCH: begin
                // PC + 4 computed by the ALU while the instruction is read.
                alusrcb     = 2'b01;
                irwrite_raw = mem_done;
                pcwrite_raw = mem_done;
                state_next  = mem_done ? S_DECODE : S_FETCH;
            end

            S_DECODE: begin
                // Branch target PC + (imm << 2) precomputed into ALUOut.
                alusrcb = 2'b11;
                // op_q is not yet valid here, so dispatch on the live opcode.
                case (op)
                    OP_LW, OP_SW:              state_next = S_MEMADR;
                    OP_RTYPE:                  state_next = S_RTYPEEX;
                    OP_BEQ, OP_BNE:            state_next = S_BRANCH;
                    OP_ADDI, OP_ORI, OP_ANDI:  state_next = S_IMMEX;
                    OP_J:                      state_next = S_JUMP;
                    default: begin
                        state_next  = S_FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end

            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                iord       = 1'b1;
                state_next = mem_done ? S_MEMWB : S_MEMRD;
            end

            S_MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
                state_next   = S_FETCH;
            end

            S_MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
                state_next   = mem_done ? S_FETCH : S_MEMWR;
            end

            S_RTYPEEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                state_next = S_RTYPEWB;
            end

            S_RTYPEWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
                state_next   = S_FETCH;
            end

            S_BRANCH: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = 2'b01;
                branch_raw = (op_q == OP_BEQ);
                bne_raw    = (op_q == OP_BNE);
                state_next = S_FETCH;
            end

            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                immext  = imm_zext;
                if (op_q == OP_ORI) begin
                    aluop = ALUOP_OR;
                end else if (op_q == OP_ANDI) begin
                    aluop = ALUOP_AND;
                end else begin
                    aluop = ALUOP_ADD;
                end
                state_next = S_IMMWB;
            end

            S_IMMWB: begin
                immext       = imm_zext;
                regwrite_raw = 1'b1;
                state_next   = S_FETCH;
            end

            S_JUMP: begin
                pcsrc       = 2'b10;
                pcwrite_raw = 1'b1;
                state_next  = S_FETCH;
            end

            default: begin
                // Unused encodings: everything stays at its zero default.
                state_next = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Reset gating of every side-effecting strobe, then PC enable
    // ------------------------------------------------------------------------
    assign irwrite    = ~reset & irwrite_raw;
    assign pcwrite    = ~reset & pcwrite_raw;
    assign branch     = ~reset & branch_raw;
    assign bne        = ~reset & bne_raw;
    assign memwrite   = ~reset & memwrite_raw;
    assign regwrite   = ~reset & regwrite_raw;
    assign illegal_op = ~reset & illegal_raw;

    assign pcen = pcwrite | (branch & zero) | (bne & ~zero);

    assign state_o = state;

endmodule
